// File: rtl/jt51_pkg.sv
// Shared constants for the JT51 key-on scheduling path: slot count, operator
// group encodings and the bit positions of operators inside a key-on mask.
package jt51_pkg;

  localparam int SLOTS  = 32;
  localparam int SLOT_W = 5;

  // Operator group = slot[4:3]; channel = slot[2:0]
  typedef enum logic [1:0] {
    OP_M1 = 2'd0,
    OP_M2 = 2'd1,
    OP_C1 = 2'd2,
    OP_C2 = 2'd3
  } op_grp_e;

  // Key-on register bit order differs from the slot order of the groups
  localparam int MASK_M1 = 0;
  localparam int MASK_C1 = 1;
  localparam int MASK_M2 = 2;
  localparam int MASK_C2 = 3;

  typedef struct packed {
    logic [2:0] ch;
    logic [3:0] mask;
  } kon_req_t;

  function automatic logic mask_bit(input logic [3:0] mask, input logic [1:0] op);
    logic bit_sel;
    case (op_grp_e'(op))
      OP_M1:   bit_sel = mask[MASK_M1];
      OP_M2:   bit_sel = mask[MASK_M2];
      OP_C1:   bit_sel = mask[MASK_C1];
      OP_C2:   bit_sel = mask[MASK_C2];
      default: bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/jt51_sh.sv
// Generic recirculating shift register advanced on cen. Storage carries no
// reset; callers flush it by feeding a known value for STAGES cen ticks.
module jt51_sh #(
  parameter int DATA_W = 1,
  parameter int STAGES = 32
) (
  input  logic              clk,
  input  logic              cen,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] drop
);

  logic [STAGES*DATA_W-1:0] bits_q;
  logic [STAGES*DATA_W-1:0] bits_d;

  always_comb begin
    bits_d = bits_q;
    if (cen) bits_d = {bits_q[(STAGES-1)*DATA_W-1:0], din};
  end

  always_ff @(posedge clk) begin
    bits_q <= bits_d;
  end

  assign drop = bits_q[STAGES*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/jt51_keyon_sched.sv
// Key-on scheduler: applies key-on register writes to the 32 operator slots
// over a full slot revolution and reports per-slot key level and edges.
module jt51_keyon_sched
  import jt51_pkg::*;
(
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  input  logic              kon_we,
  input  logic [2:0]        kon_ch,
  input  logic [3:0]        kon_mask,
  output logic              busy,
  output logic [SLOT_W-1:0] slot_out,
  output logic              kon_out,
  output logic              keyon_edge,
  output logic              keyoff_edge
);

  logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
  logic [SLOT_W-1:0] win_cnt_q, win_cnt_d;
  logic              act_vld_q, act_vld_d;
  logic              pend_vld_q, pend_vld_d;
  kon_req_t          act_req_q, act_req_d;
  kon_req_t          pend_req_q, pend_req_d;
  logic              busy_q, busy_d;
  logic [SLOT_W-1:0] slot_out_q, slot_out_d;
  logic              kon_out_q, kon_out_d;
  logic              keyon_q, keyon_d;
  logic              keyoff_q, keyoff_d;

  logic     wr;
  kon_req_t wr_req;
  logic     win_done;
  logic     sh_drop;
  logic     old_kon;
  logic     new_kon;
  logic     slot_hit;

  assign wr       = kon_we & ~rst;
  assign wr_req   = {kon_ch, kon_mask};
  assign win_done = act_vld_q & cen & (win_cnt_q == 5'd31);

  // Reset forces zeros into the loop so a long enough reset flushes all slots
  assign old_kon  = rst ? 1'b0 : sh_drop;
  assign slot_hit = act_vld_q & ~rst & (cur_slot_q[2:0] == act_req_q.ch);
  assign new_kon  = slot_hit ? mask_bit(act_req_q.mask, cur_slot_q[4:3]) : old_kon;

  jt51_sh #(
    .DATA_W (1),
    .STAGES (SLOTS)
  ) u_kon_sh (
    .clk  (clk),
    .cen  (cen),
    .din  (new_kon),
    .drop (sh_drop)
  );

  always_comb begin
    cur_slot_d = cur_slot_q;
    if (cen) cur_slot_d = cur_slot_q + 5'd1;
  end

  always_comb begin
    act_vld_d  = act_vld_q;
    act_req_d  = act_req_q;
    pend_vld_d = pend_vld_q;
    pend_req_d = pend_req_q;
    win_cnt_d  = win_cnt_q;
    if (act_vld_q && cen) win_cnt_d = win_cnt_q + 5'd1;
    if (win_done) act_vld_d = 1'b0;
    if (!act_vld_q) begin
      if (pend_vld_q) begin
        act_vld_d  = 1'b1;
        act_req_d  = pend_req_q;
        pend_vld_d = 1'b0;
        win_cnt_d  = '0;
      end else if (wr) begin
        act_vld_d = 1'b1;
        act_req_d = wr_req;
        win_cnt_d = '0;
      end
    end
    // Anything that cannot go straight to active parks here, last write wins
    if (wr && (act_vld_q || pend_vld_q)) begin
      pend_vld_d = 1'b1;
      pend_req_d = wr_req;
    end
  end

  // The incoming write is folded in so busy rises on the capturing clk
  always_comb begin
    busy_d = act_vld_q | pend_vld_q | wr;
  end

  always_comb begin
    slot_out_d = slot_out_q;
    kon_out_d  = kon_out_q;
    keyon_d    = keyon_q;
    keyoff_d   = keyoff_q;
    if (cen) begin
      slot_out_d = cur_slot_q;
      kon_out_d  = new_kon;
      keyon_d    = new_kon & ~old_kon;
      keyoff_d   = ~new_kon & old_kon;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_slot_q <= '0;
      win_cnt_q  <= '0;
      act_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      slot_out_q <= '0;
      kon_out_q  <= 1'b0;
      keyon_q    <= 1'b0;
      keyoff_q   <= 1'b0;
    end else begin
      cur_slot_q <= cur_slot_d;
      win_cnt_q  <= win_cnt_d;
      act_vld_q  <= act_vld_d;
      pend_vld_q <= pend_vld_d;
      busy_q     <= busy_d;
      slot_out_q <= slot_out_d;
      kon_out_q  <= kon_out_d;
      keyon_q    <= keyon_d;
      keyoff_q   <= keyoff_d;
    end
  end

  // Request payloads are qualified by their valid flags and need no reset
  always_ff @(posedge clk) begin
    act_req_q  <= act_req_d;
    pend_req_q <= pend_req_d;
  end

  assign busy        = busy_q;
  assign slot_out    = slot_out_q;
  assign kon_out     = kon_out_q;
  assign keyon_edge  = keyon_q;
  assign keyoff_edge = keyoff_q;

endmodule

// File: tb/tb_jt51_keyon_sched.sv
// Directed bench for jt51_keyon_sched: key-on/off edges, write queueing,
// sparse cen timing and reset flushing of the key-state loop.
module tb_jt51_keyon_sched;

  logic       rst, clk, cen, kon_we;
  logic [2:0] kon_ch;
  logic [3:0] kon_mask;
  logic       busy;
  logic [4:0] slot_out;
  logic       kon_out, keyon_edge, keyoff_edge;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;
  int cen_div  = 1;
  int cen_cnt, first_on_cen, ones, unstable, busy_low;
  logic last_cen;
  logic kon_seen [32];
  int on_q[$];
  int off_q[$];

  jt51_keyon_sched dut (
    .rst         (rst),
    .clk         (clk),
    .cen         (cen),
    .kon_we      (kon_we),
    .kon_ch      (kon_ch),
    .kon_mask    (kon_mask),
    .busy        (busy),
    .slot_out    (slot_out),
    .kon_out     (kon_out),
    .keyon_edge  (keyon_edge),
    .keyoff_edge (keyoff_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_log();
    on_q.delete();
    off_q.delete();
    cen_cnt      = 0;
    first_on_cen = 0;
    ones         = 0;
    unstable     = 0;
  endtask

  task automatic clk_step();
    logic       c, r;
    logic [7:0] prev;
    cen = (ph == 0);
    ph  = (ph + 1 >= cen_div) ? 0 : ph + 1;
    c   = cen;
    r   = rst;
    prev = {slot_out, kon_out, keyon_edge, keyoff_edge};
    @(posedge clk);
    #1;
    last_cen = c;
    if (c && !r) begin
      cen_cnt++;
      if (keyon_edge) begin
        on_q.push_back(int'(slot_out));
        if (first_on_cen == 0) first_on_cen = cen_cnt;
      end
      if (keyoff_edge) off_q.push_back(int'(slot_out));
      kon_seen[slot_out] = kon_out;
      ones += int'(kon_out);
    end else if (!c && !r && prev != {slot_out, kon_out, keyon_edge, keyoff_edge}) begin
      unstable++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  // Returns right after the cen edge that reported slot s-1, so the next
  // cen processes slot s.
  task automatic wait_slot(input int s);
    logic [4:0] tgt;
    int n;
    tgt = 5'(s - 1);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!(last_cen && slot_out == tgt) && n < 400);
    chk("wait_slot", {27'd0, slot_out}, {27'd0, tgt});
  endtask

  task automatic wait_busy_low();
    int n;
    n = 0;
    do begin
      clk_step();
      n++;
    end while (busy && n < 200);
    chk("busy_drain", {31'd0, busy}, 32'd0);
  endtask

  task automatic write(input logic [2:0] ch, input logic [3:0] mask);
    kon_we   = 1'b1;
    kon_ch   = ch;
    kon_mask = mask;
    clk_step();
    kon_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; kon_we = 1'b0; kon_ch = '0; kon_mask = '0;
    last_cen = 1'b0;
    for (int i = 0; i < 32; i++) kon_seen[i] = 1'b0;
    clear_log();

    // Reset for 40 cen, then check reset state while rst is still high
    steps(40);
    chk("rst_busy",    {31'd0, busy},        0);
    chk("rst_slot",    {27'd0, slot_out},    0);
    chk("rst_kon",     {31'd0, kon_out},     0);
    chk("rst_edges",   {30'd0, keyon_edge, keyoff_edge}, 0);
    rst = 1'b0;

    // ch3 all operators on, write captured while slot 10 is processed
    wait_slot(10);
    clear_log();
    write(3'd3, 4'hF);
    chk("t1_busy_rise", {31'd0, busy}, 1);
    steps(32);
    chk("t1_busy_32", {31'd0, busy}, 1);
    steps(1);
    chk("t1_busy_33", {31'd0, busy}, 0);
    chk("t1_on_n",  on_q.size(), 4);
    chk("t1_on0",   qat(on_q, 0), 11);
    chk("t1_on1",   qat(on_q, 1), 19);
    chk("t1_on2",   qat(on_q, 2), 27);
    chk("t1_on3",   qat(on_q, 3), 3);
    chk("t1_off_n", off_q.size(), 0);

    // ch3 mask 0x5 keeps M1/M2, drops C1/C2
    wait_slot(10);
    clear_log();
    write(3'd3, 4'h5);
    steps(33);
    chk("t2_on_n",  on_q.size(), 0);
    chk("t2_off_n", off_q.size(), 2);
    chk("t2_off0",  qat(off_q, 0), 19);
    chk("t2_off1",  qat(off_q, 1), 27);
    chk("t2_kon3",  {31'd0, kon_seen[3]},  1);
    chk("t2_kon11", {31'd0, kon_seen[11]}, 1);
    chk("t2_kon19", {31'd0, kon_seen[19]}, 0);
    chk("t2_kon27", {31'd0, kon_seen[27]}, 0);

    // Three writes back to back: middle one is overwritten in pending
    wait_slot(0);
    clear_log();
    busy_low = 0;
    write(3'd1, 4'h1);
    if (!busy) busy_low++;
    write(3'd2, 4'h2);
    if (!busy) busy_low++;
    write(3'd5, 4'h8);
    if (!busy) busy_low++;
    for (int i = 0; i < 63; i++) begin
      clk_step();
      if (!busy) busy_low++;
    end
    chk("t3_busy_cont", busy_low, 0);
    clk_step();
    chk("t3_busy_end", {31'd0, busy}, 0);
    chk("t3_on_n",  on_q.size(), 2);
    chk("t3_on0",   qat(on_q, 0), 1);
    chk("t3_on1",   qat(on_q, 1), 29);
    chk("t3_off_n", off_q.size(), 0);

    // cen 1-in-4, write landed between cen pulses while slot 10 is next
    cen_div = 4;
    ph = 0;
    wait_slot(10);
    clk_step();
    clear_log();
    write(3'd4, 4'hF);
    cen_cnt = 0;
    steps(140);
    chk("t4_on_n",   on_q.size(), 4);
    chk("t4_on0",    qat(on_q, 0), 12);
    chk("t4_on1",    qat(on_q, 1), 20);
    chk("t4_on2",    qat(on_q, 2), 28);
    chk("t4_on3",    qat(on_q, 3), 4);
    chk("t4_first",  first_on_cen, 3);
    chk("t4_stable", unstable, 0);
    chk("t4_busy",   {31'd0, busy}, 0);
    cen_div = 1;
    ph = 0;

    // Second write lands on the clk that completes the first window
    wait_slot(0);
    clear_log();
    write(3'd6, 4'h0);
    steps(31);
    write(3'd6, 4'hF);
    steps(34);
    chk("t5_busy",  {31'd0, busy}, 0);
    chk("t5_on_n",  on_q.size(), 4);
    chk("t5_on0",   qat(on_q, 0), 6);
    chk("t5_on1",   qat(on_q, 1), 14);
    chk("t5_on2",   qat(on_q, 2), 22);
    chk("t5_on3",   qat(on_q, 3), 30);
    chk("t5_off_n", off_q.size(), 0);

    // All slots on, then a short reset leaves 22 of them stale
    for (int c = 0; c < 8; c++) begin
      write(3'(c), 4'hF);
      wait_busy_low();
    end
    clear_log();
    steps(32);
    chk("t6_all_on", ones, 32);
    rst = 1'b1;
    steps(10);
    rst = 1'b0;
    clear_log();
    steps(32);
    chk("t6_short_ones",  ones, 22);
    chk("t6_short_edges", on_q.size() + off_q.size(), 0);

    // Full reset with a write attempted during it
    rst = 1'b1;
    steps(5);
    write(3'd0, 4'hF);
    steps(27);
    rst = 1'b0;
    clk_step();
    chk("t6_we_ignored", {31'd0, busy}, 0);
    clear_log();
    steps(32);
    chk("t6_full_ones",  ones, 0);
    chk("t6_full_edges", on_q.size() + off_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
